// File: rtl/axil_ram_responder.sv
// AXI-Lite slave RAM model: one outstanding write and one outstanding read, byte strobes, registered outputs.
// Define AXIL_RAM_DECERR_EN to answer out-of-range accesses with SLVERR instead of wrapping the address.
module axil_ram_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_WORDS_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam int IDX_HI    = ADDR_LSB + MEM_WORDS_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  w_state_e                w_state_q, w_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [MEM_WORDS_LOG2-1:0] aw_idx_q, aw_idx_d;
  logic                    aw_ok_q, aw_ok_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;

  r_state_e                r_state_q, r_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                      aw_hs, w_hs, ar_hs;
  logic [MEM_WORDS_LOG2-1:0] aw_idx, ar_idx;
  logic                      aw_in_range, ar_in_range;
  logic                      wr_allow, ar_allow;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      unused_sig;

  assign aw_hs = s_axil_awvalid && awready_q;
  assign w_hs  = s_axil_wvalid && wready_q;
  assign ar_hs = s_axil_arvalid && arready_q;

  // Byte offset bits are dropped: unaligned addresses act as aligned.
  assign aw_idx      = s_axil_awaddr[IDX_HI-1:ADDR_LSB];
  assign ar_idx      = s_axil_araddr[IDX_HI-1:ADDR_LSB];
  assign aw_in_range = (s_axil_awaddr[ADDR_WIDTH-1:IDX_HI] == '0);
  assign ar_in_range = (s_axil_araddr[ADDR_WIDTH-1:IDX_HI] == '0);

`ifdef AXIL_RAM_DECERR_EN
  assign wr_allow = aw_ok_q;
  assign ar_allow = ar_in_range;
`else
  assign wr_allow = 1'b1;
  assign ar_allow = 1'b1;
`endif

  assign unused_sig = ^{s_axil_awprot, s_axil_arprot,
                        s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0],
                        aw_ok_q, ar_in_range};

  assign mem_we  = (w_state_q == W_EXEC) && wr_allow;
  assign rd_word = mem[ar_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb_q[i]) mem[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = aw_idx;
          aw_ok_d   = aw_in_range;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        // Readies are registered, so they already drop in the cycle after each capture.
        if (aw_held_d && w_held_d) begin
          w_state_d = W_EXEC;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_EXEC: begin
        bvalid_d  = 1'b1;
        bresp_d   = wr_allow ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // The RAM is sampled before the same edge's write lands, giving read-before-write on collisions.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = ar_allow ? rd_word : '0;
          rresp_d   = ar_allow ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_ram_responder.sv
// Scoreboard bench for axil_ram_responder: stimulus pushes expected B/R responses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_axil_ram_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

`ifdef AXIL_RAM_DECERR_EN
  localparam logic [31:0] W0_AFTER  = 32'h12345678;
  localparam logic [31:0] OOR_RDATA = 32'h00000000;
  localparam logic [1:0]  OOR_RESP  = 2'b10;
`else
  localparam logic [31:0] W0_AFTER  = 32'h00000055;
  localparam logic [31:0] OOR_RDATA = 32'h00000055;
  localparam logic [1:0]  OOR_RESP  = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_axil_awaddr = '0;
  logic [2:0]    s_axil_awprot = 3'b000;
  logic          s_axil_awvalid = 1'b0;
  logic          s_axil_awready;
  logic [DW-1:0] s_axil_wdata = '0;
  logic [SW-1:0] s_axil_wstrb = '0;
  logic          s_axil_wvalid = 1'b0;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready = 1'b1;
  logic [AW-1:0] s_axil_araddr = '0;
  logic [2:0]    s_axil_arprot = 3'b000;
  logic          s_axil_arvalid = 1'b0;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready = 1'b1;

  axil_ram_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .MEM_WORDS_LOG2(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_r(input logic [31:0] data, input logic [1:0] resp);
    rexp_t e;
    e.data = data;
    e.resp = resp;
    exp_r.push_back(e);
  endtask

  // Monitor: every handshake on B or R is checked against the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [1:0] eb;
    rexp_t      er;
    if (s_axil_bvalid && s_axil_bready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected", 64'(s_axil_bvalid), 64'(1'b0));
      end else begin
        eb = exp_b.pop_front();
        check("bresp", 64'(s_axil_bresp), 64'(eb));
      end
    end
    if (s_axil_rvalid && s_axil_rready) begin
      if (exp_r.size() == 0) begin
        check("r_unexpected", 64'(s_axil_rvalid), 64'(1'b0));
      end else begin
        er = exp_r.pop_front();
        check("rdata", 64'(s_axil_rdata), 64'(er.data));
        check("rresp", 64'(s_axil_rresp), 64'(er.resp));
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [1:0] resp,
                           output int lat, output int stray);
    bit aw_done, w_done, aw_go, w_go, got;
    int hs_cyc;
    exp_b.push_back(resp);
    s_axil_awaddr = addr;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    s_axil_bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; got = 1'b0;
    hs_cyc = 0; lat = -1; stray = 0;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      s_axil_awvalid = !aw_done && (n >= aw_dly);
      s_axil_wvalid  = !w_done && (n >= w_dly);
      @(negedge clk);
      if ((aw_done && s_axil_awready) || (w_done && s_axil_wready)) stray++;
      aw_go = s_axil_awvalid && s_axil_awready;
      w_go  = s_axil_wvalid && s_axil_wready;
      if (aw_go || w_go) hs_cyc = cyc;
      @(posedge clk); #1;
      aw_done = aw_done | aw_go;
      w_done  = w_done | w_go;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    check("aw_w_accept", 64'({aw_done, w_done}), 64'(2'b11));
    if (!(aw_done && w_done)) begin
      void'(exp_b.pop_back());
      return;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_awready || s_axil_wready) stray++;
      if (s_axil_bvalid) begin
        got = 1'b1;
        lat = cyc - hs_cyc;
      end
      @(posedge clk); #1;
    end
    check("bvalid_seen", 64'(got), 64'(1'b1));
    if (!got) void'(exp_b.pop_back());
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          output int lat);
    bit done, got;
    int hs_cyc;
    push_r(data, resp);
    s_axil_araddr = addr;
    s_axil_rready = 1'b1;
    done = 1'b0; got = 1'b0; hs_cyc = 0; lat = -1;
    for (int n = 0; n < 20 && !done; n++) begin
      s_axil_arvalid = 1'b1;
      @(negedge clk);
      if (s_axil_arready) begin
        done = 1'b1;
        hs_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    s_axil_arvalid = 1'b0;
    check("ar_accept", 64'(done), 64'(1'b1));
    if (!done) begin
      void'(exp_r.pop_back());
      return;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (s_axil_rvalid) begin
        got = 1'b1;
        lat = cyc - hs_cyc;
      end
      @(posedge clk); #1;
    end
    check("rvalid_seen", 64'(got), 64'(1'b1));
    if (!got) void'(exp_r.pop_back());
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lat, stray;

    // Reset and release
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
               s_axil_bresp, s_axil_rresp, s_axil_rdata}), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("readies_before_edge", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b000));
    @(negedge clk);
    check("readies_after_release", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
    @(posedge clk); #1;

    // AW and W together, then readback
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, lat, stray);
    check("t1_b_latency", 64'(lat), 64'(2));
    check("t1_readies_low", 64'(stray), 64'(0));
    axi_read(32'h10, 32'hDEADBEEF, 2'b00, lat);
    check("t1_r_latency", 64'(lat), 64'(1));

    // W three cycles ahead of AW
    axi_write(32'h20, 32'h11223344, 4'hF, 3, 0, 2'b00, lat, stray);
    check("t2_b_latency", 64'(lat), 64'(2));
    check("t2_readies_low", 64'(stray), 64'(0));
    axi_read(32'h20, 32'h11223344, 2'b00, lat);

    // Byte strobes, including an all-zero strobe
    axi_write(32'h30, 32'hAABBCCDD, 4'hF, 0, 0, 2'b00, lat, stray);
    axi_write(32'h30, 32'h00000011, 4'h1, 0, 2, 2'b00, lat, stray);
    check("t3_aw_first_latency", 64'(lat), 64'(2));
    axi_read(32'h30, 32'hAABBCC11, 2'b00, lat);
    axi_write(32'h33, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00, lat, stray);
    axi_read(32'h31, 32'hAABBCC11, 2'b00, lat);

    // Backpressure on B and R for five cycles
    exp_b.push_back(2'b00);
    push_r(32'hDEADBEEF, 2'b00);
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    s_axil_awaddr = 32'h40; s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF;
    s_axil_araddr = 32'h10;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    @(negedge clk);
    check("bp_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold_flags",
            64'({s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready, s_axil_arready,
                 s_axil_bresp, s_axil_rresp}), 64'(9'b11000_00_00));
      check("bp_hold_rdata", 64'(s_axil_rdata), 64'(32'hDEADBEEF));
      @(posedge clk); #1;
    end
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release",
          64'({s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready, s_axil_arready}),
          64'(5'b00111));
    @(posedge clk); #1;
    axi_read(32'h40, 32'hCAFEF00D, 2'b00, lat);

    // Read in the write-execute cycle of the same word sees old data
    axi_write(32'h50, 32'h0BADF00D, 4'hF, 0, 0, 2'b00, lat, stray);
    exp_b.push_back(2'b00);
    push_r(32'h0BADF00D, 2'b00);
    s_axil_awaddr = 32'h50; s_axil_wdata = 32'h600DCAFE; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    @(negedge clk);
    check("col_aw_w_ready", 64'({s_axil_awready, s_axil_wready}), 64'(2'b11));
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 32'h50; s_axil_arvalid = 1'b1;
    @(negedge clk);
    check("col_arready", 64'(s_axil_arready), 64'(1'b1));
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    axi_read(32'h50, 32'h600DCAFE, 2'b00, lat);

    // Out-of-range write and reads
    axi_write(32'h000, 32'h12345678, 4'hF, 0, 0, 2'b00, lat, stray);
    axi_write(32'h400, 32'h00000055, 4'hF, 0, 0, OOR_RESP, lat, stray);
    check("oor_b_latency", 64'(lat), 64'(2));
    axi_read(32'h000, W0_AFTER, 2'b00, lat);
    axi_read(32'h400, OOR_RDATA, OOR_RESP, lat);
    check("oor_r_latency", 64'(lat), 64'(1));

    // Reset while both responses are pending
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    s_axil_awaddr = 32'h60; s_axil_wdata = 32'h13579BDF; s_axil_wstrb = 4'hF;
    s_axil_araddr = 32'h10;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rm_pending", 64'({s_axil_bvalid, s_axil_rvalid}), 64'(2'b11));
    rst = 1'b0;
    #1;
    check("rm_async_clear",
          64'({s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready, s_axil_arready}),
          64'(5'b00000));
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rm_before_edge",
          64'({s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready, s_axil_arready}),
          64'(5'b00000));
    @(negedge clk);
    check("rm_readies_up",
          64'({s_axil_bvalid, s_axil_rvalid, s_axil_awready, s_axil_wready, s_axil_arready}),
          64'(5'b00111));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rm_no_response", 64'({s_axil_bvalid, s_axil_rvalid}), 64'(2'b00));
    end
    @(posedge clk); #1;
    axi_read(32'h10, 32'hDEADBEEF, 2'b00, lat);

    repeat (4) @(posedge clk);
    #1;
    check("b_queue_drained", 64'(exp_b.size()), 64'(0));
    check("r_queue_drained", 64'(exp_r.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_ram_responder.md
Name: axil_ram_responder

Overview:
- AXI-Lite slave memory model that terminates the bridge's AXI-Lite master port.
- It accepts single-beat reads and writes into an internal word-addressed RAM and returns OKAY/SLVERR responses.
- It is used in the bridge bench as the downstream target and as a standalone responder for end-to-end data checks.
- It supports one outstanding write and one outstanding read.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width (32 or 64).
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width.
- MEM_WORDS_LOG2, 8, log2 of RAM depth in words (256 words by default).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  write protection (ignored).
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  write byte strobes.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  read protection (ignored).
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.

Behaviour:
- Reset (rst low, asynchronous):
  - awready, wready, arready, bvalid and rvalid are 0.
  - bresp, rresp and rdata are 0.
  - AW/W holding registers are cleared.
  - RAM contents are not reset (undefined until written).
- Readies rise on the first clk edge after rst deasserts.
- Address decode:
  - ADDR_LSB = log2(STRB_WIDTH).
  - Word index = addr[ADDR_LSB+MEM_WORDS_LOG2-1 : ADDR_LSB].
  - Low ADDR_LSB bits are ignored (unaligned address is treated as aligned).
  - An address is in range when addr[ADDR_WIDTH-1 : ADDR_LSB+MEM_WORDS_LOG2] == 0.
- Write path, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE:
    - awready = !aw_held; wready = !w_held.
    - AW and W are captured independently and in either order; both in the same cycle is allowed.
    - When both are held (including captured this cycle), go to W_EXEC next cycle.
  - W_EXEC: one cycle.
    - RAM bytes are written where wstrb[i] = 1; wstrb = 0 writes nothing but still responds.
    - bvalid is asserted; go to W_RESP.
  - W_RESP:
    - bvalid holds with a stable bresp until bready.
    - On the handshake: bvalid drops, holding registers clear, return to W_IDLE.
    - awready/wready are 0 throughout W_EXEC and W_RESP.
  - Latency: bvalid is high 2 cycles after the later of AW/W handshakes, minimum.
- Read path, states R_IDLE, R_RESP:
  - R_IDLE: arready = 1. On the AR handshake, RAM is read and rdata/rresp registered; rvalid rises the next cycle (1-cycle latency).
  - R_RESP:
    - arready = 0.
    - rvalid, rdata and rresp are stable until rready.
    - On the handshake: rvalid drops and the path returns to R_IDLE.
    - No back-to-back AR in the handshake cycle; maximum throughput is 1 read per 2 cycles.
- Read/write collision:
  - An AR handshake in the same cycle as W_EXEC to the same word returns the old data (read-before-write).
- Channel independence:
  - Read and write paths are fully independent; neither stalls the other.
- Handshake rules:
  - No valid output depends combinationally on a ready input.
  - Outputs are registered.
- rst asserted mid-transaction aborts every state immediately to idle; no response is issued for the aborted transaction.

Optional Feature:
- Macro: AXIL_RAM_DECERR_EN.
- Defined:
  - An out-of-range write returns bresp = 2'b10 (SLVERR) and does not modify the RAM.
  - An out-of-range read returns rresp = 2'b10 with rdata = 0.
  - Timing is unchanged.
- Undefined:
  - Upper address bits are ignored, so the address wraps modulo 2^(MEM_WORDS_LOG2+ADDR_LSB).
  - All responses are 2'b00 (OKAY).

Test Plan:
- Write/read same cycle order:
  - Stimulus: AW=0x10 and W=0xDEADBEEF with strb=0xF in the same cycle, bready=1; then AR=0x10, rready=1.
  - Required: bvalid 2 cycles after the handshake, bresp=0; rvalid 1 cycle after AR; rdata=0xDEADBEEF, rresp=0.
- W before AW:
  - Stimulus: W=0x11223344 at cycle 0, AW=0x20 at cycle 3.
  - Required: wready low cycles 1-3; bvalid at cycle 5; a readback of 0x20 returns 0x11223344.
- Byte strobes:
  - Stimulus: write 0xAABBCCDD to 0x30, then write 0x00000011 with strb=0x1.
  - Required: readback = 0xAABBCC11.
- Response backpressure:
  - Stimulus: hold bready=0 and rready=0 for 5 cycles.
  - Required: bvalid/rvalid and the response data are stable; awready, wready and arready stay 0; each channel completes one cycle after its ready rises.
- Out-of-range access:
  - Stimulus: write 0x55 to 0x400 (depth 256), then read 0x000.
  - Required with AXIL_RAM_DECERR_EN: bresp=2'b10; word 0 unchanged; a read of 0x400 gives rresp=2'b10, rdata=0.
  - Required without AXIL_RAM_DECERR_EN: word 0 = 0x55, OKAY.
- Reset mid-transaction:
  - Stimulus: pull rst low while bvalid=1 and rvalid=1.
  - Required: bvalid and rvalid go to 0 asynchronously; no response after release; readies are 1 one cycle after release.
